freq_gate_ctrl: RTL
===================

// Module: freq_gate_ctrl
// PURPOSE
//  Measurement sequencer for the frequency meter. Owns the gate-time window and
//  drives the BCD edge counter's enable, synchronous clear and display latch.
//  Supports four decade gate ranges (manual, or automatic overflow/underrange stepping).
//  Sits between the 1 MHz timebase tick, the edge detector and bcd_counter.
// PARAMETERS
//  GATE_BASE   24'd10_000   us ticks in range-0 gate (10 ms); range n = GATE_BASE*10^n
//  HOLD_TICKS  20'd100_000  us ticks the latched reading is held before re-arming
//  RANGE_RST   2'd2         range after reset (1 s gate with defaults)
// PORTS
//  fpga_clk   in   1   system clock; all logic on rising edge
//  reset      in   1   asynchronous, active-high reset
//  tick_1us   in   1   1-cycle strobe at 1 MHz from the prescaler
//  sig_edge   in   1   1-cycle strobe per synchronized rising edge of the input signal
//  carry_out  in   1   bcd_counter carry out of the most significant digit (overflow)
//  msd_zero   in   1   bcd_counter live most significant digit == 0
//  run        in   1   1 = continuous measurement, 0 = stop
//  range_sel  in   2   manual range (used without auto-ranging)
//  count_en   out  1   clk_enable to bcd_counter
//  reset_ctr  out  1   1-cycle synchronous clear to bcd_counter
//  latchit    out  1   1-cycle latch of count into display register
//  gate_open  out  1   high while the gate window is open
//  range      out  2   range of current/last gate (drives decimal point)
//  ovf        out  1   last latched reading overflowed
// BEHAVIOUR
//  - Reset: state IDLE; count_en, reset_ctr, latchit, gate_open, ovf = 0; range = RANGE_RST.
//  - Gate counter 24 b, hold counter 20 b; count only on tick_1us.
//  - FSM: IDLE -> CLEAR -> ARM -> GATE -> EVAL -> LATCH -> HOLD -> CLEAR ...
//    IDLE: wait run=1 -> CLEAR.
//    CLEAR: reset_ctr=1 one cycle; clear internal ovf_seen -> ARM.
//    ARM: on tick_1us load gate count GATE_BASE*10^range -> GATE (aligns gate to tick).
//    GATE: gate_open=1; count_en = sig_edge (combinational, same cycle);
//      carry_out=1 sets ovf_seen; decrement on tick; tick with count==1 -> EVAL.
//    EVAL: one cycle; decides latch vs. re-range (see CONFIGURATION).
//    LATCH: latchit=1 one cycle; ovf <= ovf_seen -> HOLD.
//    HOLD: count HOLD_TICKS ticks, then run ? CLEAR : IDLE.
//  - sig_edge on the closing tick cycle IS counted; carry_out on that cycle IS captured.
//  - run=0 in CLEAR/ARM/GATE/EVAL: next state IDLE, no latchit, displayed value and ovf kept.
//  - run=0 in HOLD: finish hold, then IDLE.
//  - range only changes in EVAL (auto) or when loaded in ARM (manual); stable during gate.
//  - reset mid-gate: async return to IDLE, all outputs to reset values.
// CONFIGURATION
//  FREQ_AUTORANGE_EN defined:
//   - range_sel ignored; range held in register.
//   - EVAL: ovf_seen & range>0 -> range-1, skip LATCH, go CLEAR (re-measure).
//   - EVAL: !ovf_seen & msd_zero & range<3 -> range+1, go LATCH (reading valid).
//   - ovf_seen at range 0 -> LATCH with ovf=1. Otherwise -> LATCH, range unchanged.
//  FREQ_AUTORANGE_EN undefined:
//   - range <= range_sel in ARM; EVAL always -> LATCH; ovf reports overflow.
// TESTING  (GATE_BASE=10, HOLD_TICKS=5, tick_1us every 4 clocks)
//  1 reset high, any inputs -> all outputs 0, range=2; release with run=0 -> stays IDLE.
//  2 manual range_sel=0, run=1, sig_edge on every tick -> exactly 10 count_en pulses,
//    gate_open 40 clocks, one reset_ctr before gate, one latchit after, ovf=0.
//  3 manual range 0, carry_out pulse mid-gate -> latchit still pulses, ovf=1;
//    next clean gate -> ovf=0.
//  4 FREQ_AUTORANGE_EN, range=2, carry_out in gate -> no latchit, range=1,
//    reset_ctr, next gate 100 ticks.
//  5 FREQ_AUTORANGE_EN, msd_zero=1 at EVAL, range=1 -> latchit, range=2;
//    at range=3 -> range stays 3.
//  6 run dropped 3 ticks into gate -> IDLE next clock, count_en=0, no latchit, ovf unchanged.

Source files
------------

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: measurement sequencer for the frequency meter.
// Owns the gate window and drives enable/clear/latch of the BCD edge counter.
// Optional feature: define FREQ_AUTORANGE_EN for automatic decade range stepping;
// without it the range follows range_sel, sampled when each gate is armed.
module freq_gate_ctrl #(
   parameter logic [23:0] GATE_BASE  = 24'd10_000,
   parameter logic [19:0] HOLD_TICKS = 20'd100_000,
   parameter logic [1:0]  RANGE_RST  = 2'd2
) (
   input  logic       fpga_clk,
   input  logic       reset,
   input  logic       tick_1us,
   input  logic       sig_edge,
   input  logic       carry_out,
   input  logic       msd_zero,
   input  logic       run,
   input  logic [1:0] range_sel,
   output logic       count_en,
   output logic       reset_ctr,
   output logic       latchit,
   output logic       gate_open,
   output logic [1:0] range,
   output logic       ovf
);

   typedef enum logic [2:0] {
      IDLE, CLEAR, ARM, GATE, EVAL, LATCH, HOLD
   } state_t;

   state_t      state;
   logic [23:0] gate_cnt;
   logic [19:0] hold_cnt;
   logic        ovf_seen;
   logic [1:0]  load_range;

`ifdef FREQ_AUTORANGE_EN
   logic [1:0] unused_range_sel;
   assign unused_range_sel = range_sel;
   assign load_range       = range;
`else
   logic unused_msd_zero;
   assign unused_msd_zero = msd_zero;
   assign load_range      = range_sel;
`endif

   // Gate length in us ticks for a decade range.
   function automatic logic [23:0] gate_len(input logic [1:0] r);
      case (r)
         2'd0:    return GATE_BASE;
         2'd1:    return GATE_BASE * 24'd10;
         2'd2:    return GATE_BASE * 24'd100;
         default: return GATE_BASE * 24'd1000;
      endcase
   endfunction

   // Edges pass straight through to the counter only while the gate is open.
   assign count_en = gate_open & sig_edge;

   // Sequencer; pulse outputs are raised on the transition into their state,
   // so each one is high exactly while the FSM sits in CLEAR / LATCH / GATE.
   always_ff @(posedge fpga_clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         gate_cnt  <= '0;
         hold_cnt  <= '0;
         ovf_seen  <= 1'b0;
         reset_ctr <= 1'b0;
         latchit   <= 1'b0;
         gate_open <= 1'b0;
         range     <= RANGE_RST;
         ovf       <= 1'b0;
      end else begin
         reset_ctr <= 1'b0;
         latchit   <= 1'b0;
         gate_open <= 1'b0;
         case (state)
            IDLE: begin
               if (run) begin
                  state     <= CLEAR;
                  reset_ctr <= 1'b1;
               end
            end
            CLEAR: begin
               ovf_seen <= 1'b0;
               state    <= run ? ARM : IDLE;
            end
            ARM: begin
               if (!run) begin
                  state <= IDLE;
               end else if (tick_1us) begin
                  gate_cnt  <= gate_len(load_range);
                  range     <= load_range;
                  gate_open <= 1'b1;
                  state     <= GATE;
               end
            end
            GATE: begin
               if (carry_out) ovf_seen <= 1'b1;
               if (!run) begin
                  state <= IDLE;
               end else if (tick_1us && gate_cnt == 24'd1) begin
                  state <= EVAL;
               end else begin
                  gate_open <= 1'b1;
                  if (tick_1us) gate_cnt <= gate_cnt - 24'd1;
               end
            end
            EVAL: begin
               if (!run) begin
                  state <= IDLE;
`ifdef FREQ_AUTORANGE_EN
               end else if (ovf_seen && range != 2'd0) begin
                  // Overflowed on a longer gate: shorten and re-measure without latching.
                  range     <= range - 2'd1;
                  reset_ctr <= 1'b1;
                  state     <= CLEAR;
               end else begin
                  if (!ovf_seen && msd_zero && range != 2'd3) range <= range + 2'd1;
                  latchit <= 1'b1;
                  state   <= LATCH;
               end
`else
               end else begin
                  latchit <= 1'b1;
                  state   <= LATCH;
               end
`endif
            end
            LATCH: begin
               ovf      <= ovf_seen;
               hold_cnt <= HOLD_TICKS;
               state    <= HOLD;
            end
            HOLD: begin
               if (tick_1us) begin
                  if (hold_cnt == 20'd1) begin
                     if (run) begin
                        reset_ctr <= 1'b1;
                        state     <= CLEAR;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     hold_cnt <= hold_cnt - 20'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
